gzip_out_axis_bridge: RTL and testbench

GZIP_OUT_AXIS_BRIDGE -- requirements
Module: gzip_out_axis_bridge

---
 rtl/gzip_out_axis_bridge_pkg.sv | 18 +
 rtl/gzip_out_axis_bridge_if.sv | 26 ++
 rtl/gzip_skid_fifo.sv | 66 ++++++
 rtl/gzip_out_axis_bridge.sv | 147 ++++++++++++++
 tb/tb_gzip_out_axis_bridge.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gzip_out_axis_bridge_pkg.sv
// Shared definitions for the gzip output AXI-Stream bridge: FSM encoding,
// default sizes and a saturating counter helper.
package gzip_out_axis_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    localparam int GZIP_BUF_DEPTH  = 4;
    localparam int GZIP_DATA_WIDTH = 32;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/gzip_out_axis_bridge_if.sv
// Bundles the core-FIFO read port and the AXI-Stream master port of the bridge.
interface gzip_out_axis_bridge_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rden;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_last;

    // AXI-Stream: a beat transfers on a cycle with m_tvalid & m_tready; once
    // m_tvalid rises, m_tdata/m_tlast hold until that transfer happens.
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (
        input  fifo_empty, fifo_data, fifo_last, m_tready,
        output fifo_rden, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output fifo_empty, fifo_data, fifo_last, m_tready,
        input  fifo_rden, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/gzip_skid_fifo.sv
// Small circular FIFO that absorbs the one-cycle read latency of the core
// output FIFO so the stream side can run at full rate under backpressure.
module gzip_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   occ_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic             push_ok, pop_ok;

    // Guards keep occupancy inside [0, DEPTH] even if a caller misbehaves.
    assign pop_ok  = pop_i && (occ_q != '0);
    assign push_ok = push_i && ((occ_q != FULL_OCC) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/gzip_out_axis_bridge.sv
// Bridges the gzip core's read-latency-1 output FIFO onto an AXI-Stream master,
// keeping frames separated and reporting per-frame word counts plus an irq.
module gzip_out_axis_bridge
    import gzip_out_axis_bridge_pkg::*;
#(
    parameter int BUF_DEPTH  = GZIP_BUF_DEPTH,
    parameter int DATA_WIDTH = GZIP_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    gzip_out_axis_bridge_if.master      bus,
    output logic [31:0]                 frame_words,
    output logic [15:0]                 frame_count,
    output logic                        frame_done,
    output logic                        irq,
    input  logic                        irq_clear,
    output state_e                      state_o,
    output logic [$clog2(BUF_DEPTH):0]  occ_o
);
    localparam int OW = $clog2(BUF_DEPTH) + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(BUF_DEPTH);

    state_e              state_q, state_d;
    logic                inflight_q;
    logic                run_q;
    logic [31:0]         word_cnt_q, word_cnt_d;
    logic [31:0]         frame_words_q, frame_words_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                frame_done_q, frame_done_d;
    logic                irq_q, irq_d;

    logic [OW-1:0]       occ;
    logic [DATA_WIDTH:0] head;
    logic                push, pop, tvalid, last_arriving, rden;

    assign tvalid        = (occ != '0);
    assign push          = inflight_q;
    assign pop           = tvalid & bus.m_tready;
    assign last_arriving = inflight_q & bus.fifo_last;

    // Reads depend only on registered state and FIFO inputs, never on
    // m_tready. The last_arriving term also stops the read that would
    // otherwise be issued in the cycle the tlast word lands, so no word of
    // the next frame can slip into the buffer behind it. run_q holds reads
    // off for the first cycle after reset release.
    assign rden = run_q
                & ~bus.fifo_empty
                & ((occ + OW'(inflight_q)) < DEPTH_W)
                & (state_q != ST_FLUSH)
                & ~last_arriving;

    gzip_skid_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({bus.fifo_last, bus.fifo_data}),
        .pop_i       (pop),
        .head_o      (head),
        .occ_o       (occ)
    );

    // Head is masked while empty so the stream reads as zero at rest.
    assign bus.fifo_rden = rden;
    assign bus.m_tvalid  = tvalid;
    assign bus.m_tdata   = tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign bus.m_tlast   = tvalid & head[DATA_WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    state_d = bus.fifo_last ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (push && bus.fifo_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (pop && bus.m_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        word_cnt_d    = word_cnt_q;
        frame_words_d = frame_words_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        if (pop) begin
            if (bus.m_tlast) begin
                frame_words_d = sat_inc32(word_cnt_q);
                word_cnt_d    = '0;
                frame_count_d = frame_count_q + 16'd1;
                frame_done_d  = 1'b1;
            end else begin
                word_cnt_d = sat_inc32(word_cnt_q);
            end
        end
        // A frame_done in the same cycle as irq_clear keeps the irq set.
        irq_d = frame_done_q | (irq_q & ~irq_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            run_q         <= 1'b0;
            word_cnt_q    <= '0;
            frame_words_q <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            inflight_q    <= rden;
            run_q         <= 1'b1;
            word_cnt_q    <= word_cnt_d;
            frame_words_q <= frame_words_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
            irq_q         <= irq_d;
        end
    end

    assign frame_words = frame_words_q;
    assign frame_count = frame_count_q;
    assign frame_done  = frame_done_q;
    assign irq         = irq_q;
    assign state_o     = state_q;
    assign occ_o       = occ;

endmodule

// File: tb/tb_gzip_out_axis_bridge.sv
// Directed and randomized checks of gzip_out_axis_bridge against a queue-based
// model of the upstream FIFO, the expected beat stream and the frame statistics.
module tb_gzip_out_axis_bridge;
    import gzip_out_axis_bridge_pkg::*;

    localparam int DW = 32;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gzip_out_axis_bridge_if #(.DATA_WIDTH(DW)) ifc ();

    logic [31:0]          frame_words;
    logic [15:0]          frame_count;
    logic                 frame_done;
    logic                 irq;
    logic                 irq_clear;
    state_e               state_dbg;
    logic [$clog2(BD):0]  occ_dbg;

    gzip_out_axis_bridge #(.BUF_DEPTH(BD), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ifc.master),
        .frame_words (frame_words),
        .frame_count (frame_count),
        .frame_done  (frame_done),
        .irq         (irq),
        .irq_clear   (irq_clear),
        .state_o     (state_dbg),
        .occ_o       (occ_dbg)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW:0] src_q[$];
    logic [DW:0] exp_q[$];
    logic [31:0] fw_log[$];

    int   cyc = 0;
    int   rdy_mode = 0;
    bit   gap_en = 0;
    bit   rden_n = 0;
    bit   last_out = 0;

    logic [31:0] exp_fw;
    logic [15:0] exp_fc;
    bit          done_exp, irq_exp;
    int          beats;
    bit          stall_prev;
    logic [DW:0] stall_word;

    int first_rden_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc, acc_total;
    bit seen_stream, seen_flush;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Upstream FIFO model: one-cycle read latency, garbage when not read.
    always @(negedge clk) rden_n = ifc.fifo_rden;
    always @(posedge clk) begin
        logic [DW:0] w;
        #1;
        if (rst_n && rden_n && src_q.size() != 0) begin
            w = src_q.pop_front();
            ifc.fifo_data = w[DW-1:0];
            ifc.fifo_last = w[DW];
            if (w[DW]) last_out = 1'b1;
        end else begin
            ifc.fifo_data = $urandom;
            ifc.fifo_last = 1'($urandom_range(0, 1));
        end
        ifc.fifo_empty = (src_q.size() == 0) || (gap_en && ($urandom_range(0, 3) == 0));
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ifc.m_tready = 1'b1;
            1:       ifc.m_tready = ~ifc.m_tready;
            default: ifc.m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor and scoreboard.
    always @(negedge clk) begin
        logic [DW:0] w, got;
        if (!rst_n) begin
            exp_fw = '0; exp_fc = '0; done_exp = 0; irq_exp = 0; beats = 0; stall_prev = 0;
        end else begin
            got = {ifc.m_tlast, ifc.m_tdata};
            if (ifc.fifo_rden) begin
                check("read_while_tlast_pending", 64'(last_out), 0);
                if (first_rden_cyc < 0) first_rden_cyc = cyc;
            end
            if (ifc.m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (state_dbg == ST_STREAM) seen_stream = 1;
            if (state_dbg == ST_FLUSH) seen_flush = 1;
            check("occ_bound", 64'(occ_dbg <= BD), 1);
            if (stall_prev) begin
                check("stall_valid", 64'(ifc.m_tvalid), 1);
                check("stall_data", 64'(got), 64'(stall_word));
            end
            check("frame_done", 64'(frame_done), 64'(done_exp));
            check("frame_words", 64'(frame_words), 64'(exp_fw));
            check("frame_count", 64'(frame_count), 64'(exp_fc));
            check("irq", 64'(irq), 64'(irq_exp));
            if (frame_done) fw_log.push_back(frame_words);
            irq_exp  = done_exp ? 1'b1 : (irq_clear ? 1'b0 : irq_exp);
            done_exp = 0;
            if (ifc.m_tvalid && ifc.m_tready) begin
                acc_total++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                check("beat_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("beat", 64'(got), 64'(w));
                    if (w[DW]) begin
                        exp_fw = 32'(beats + 1);
                        beats = 0;
                        exp_fc = exp_fc + 16'd1;
                        done_exp = 1;
                        last_out = 0;
                    end else begin
                        beats++;
                    end
                end
            end
            stall_prev = ifc.m_tvalid && !ifc.m_tready;
            stall_word = got;
        end
    end

    task automatic reset_trackers();
        first_rden_cyc = -1; first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
        acc_total = 0; seen_stream = 0; seen_flush = 0; fw_log.delete();
    endtask

    task automatic load_word(input bit last, input logic [DW-1:0] data);
        src_q.push_back({last, data});
        exp_q.push_back({last, data});
        ifc.fifo_empty = 1'b0;
    endtask

    task automatic load_frame(input int n, input bit rnd, input logic [DW-1:0] base);
        @(posedge clk); #2;
        for (int i = 0; i < n; i++) begin
            load_word(i == n - 1, rnd ? DW'($urandom) : base + DW'(i));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rden"}, 64'(ifc.fifo_rden), 0);
        check({tag, "_tvalid"}, 64'(ifc.m_tvalid), 0);
        check({tag, "_tlast"}, 64'(ifc.m_tlast), 0);
        check({tag, "_tdata"}, 64'(ifc.m_tdata), 0);
        check({tag, "_fw"}, 64'(frame_words), 0);
        check({tag, "_fc"}, 64'(frame_count), 0);
        check({tag, "_irq"}, 64'(irq), 0);
        check({tag, "_done"}, 64'(frame_done), 0);
        check({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
        check({tag, "_occ"}, 64'(occ_dbg), 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        rst_n = 1'b0;
        src_q.delete(); exp_q.delete(); last_out = 0; ifc.fifo_empty = 1'b1;
        @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk); #2;
        reset_trackers();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int i = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_drain_timeout"}, 64'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int i;
        ifc.fifo_empty = 1'b1; ifc.fifo_data = '0; ifc.fifo_last = 1'b0; ifc.m_tready = 1'b1;
        irq_clear = 1'b0;
        reset_trackers();

        // Continuous 8-word frame, data preloaded while still in reset.
        repeat (2) @(posedge clk);
        load_frame(8, 0, 32'h1);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #2;
        reset_trackers();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_release_rden", 64'(ifc.fifo_rden), 0);
        check("post_release_tvalid", 64'(ifc.m_tvalid), 0);
        check("post_release_tdata", 64'(ifc.m_tdata), 0);
        wait_drain("t1");
        check("t1_fw", 64'(frame_words), 8);
        check("t1_fc", 64'(frame_count), 1);
        check("t1_irq", 64'(irq), 1);
        check("t1_fill_latency", 64'(first_valid_cyc - first_rden_cyc), 2);
        check("t1_back_to_back", 64'(last_acc_cyc - first_acc_cyc), 7);

        // Plain irq acknowledge.
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        @(negedge clk);
        check("irq_cleared", 64'(irq), 0);

        // Single-word frame with irq_clear coinciding with frame_done.
        reset_trackers();
        load_frame(1, 0, 32'hDEADBEEF);
        i = 0;
        while (!frame_done && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("t3_done_seen", 64'(frame_done), 1);
        irq_clear = 1'b1;
        @(negedge clk);
        check("t3_irq_set_wins", 64'(irq), 1);
        @(negedge clk);
        irq_clear = 1'b0;
        check("t3_irq_clear_later", 64'(irq), 0);
        check("t3_fw", 64'(frame_words), 1);
        check("t3_fc", 64'(frame_count), 2);
        check("t3_no_stream_state", 64'(seen_stream), 0);
        check("t3_flush_seen", 64'(seen_flush), 1);
        check("t3_back_idle", 64'(state_dbg), 64'(ST_IDLE));

        // 16-word frame with m_tready toggling.
        do_reset("rst_t4");
        rdy_mode = 1;
        load_frame(16, 1, '0);
        wait_drain("t4");
        check("t4_fw", 64'(frame_words), 16);
        check("t4_fc", 64'(frame_count), 1);

        // Back-to-back 3- and 5-word frames, upstream never empty.
        do_reset("rst_t5");
        rdy_mode = 0;
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) load_word(k == 2, 32'h100 + 32'(k));
        for (int k = 0; k < 5; k++) load_word(k == 4, 32'h200 + 32'(k));
        wait_drain("t5");
        check("t5_frames_logged", 64'(fw_log.size()), 2);
        if (fw_log.size() == 2) begin
            check("t5_fw_first", 64'(fw_log[0]), 3);
            check("t5_fw_second", 64'(fw_log[1]), 5);
        end
        check("t5_fc", 64'(frame_count), 2);

        // Random frames, random ready, upstream gaps.
        do_reset("rst_t6");
        rdy_mode = 2;
        gap_en = 1;
        for (int f = 0; f < 6; f++) load_frame($urandom_range(1, 7), 1, '0);
        wait_drain("t6");
        check("t6_fc", 64'(frame_count), 6);
        gap_en = 0;

        // Reset in the middle of a 6-word frame, then a fresh 2-word frame.
        do_reset("rst_t7");
        rdy_mode = 0;
        load_frame(6, 0, 32'h600);
        i = 0;
        while (acc_total < 3 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("t7_three_accepted", 64'(acc_total), 3);
        do_reset("rst_mid");
        load_frame(2, 0, 32'h700);
        wait_drain("t7");
        check("t7_fw", 64'(frame_words), 2);
        check("t7_fc", 64'(frame_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
